// File: rtl/keypad_scan_controller.sv
// rtl/keypad_scan_controller.sv - 4x4 keypad scanner with frame debounce and key-event FIFO
module keypad_scan_controller #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int CNT_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       rows,
  output logic [3:0]       cols,
  input  logic             rd_en,
  input  logic             clr_ovf,
  output logic [31:0]      rd_data,
  output logic             empty,
  output logic             overflow,
  output logic [CNT_W-1:0] level
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX    = STB_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] LVL_FULL   = CNT_W'(FIFO_DEPTH);

  // Scan state
  logic [1:0]       r_col_idx;
  logic [DIV_W-1:0] r_dwell;
  logic [11:0]      r_frame_acc;
  logic [15:0]      r_frame;
  logic             r_frame_vld;
  logic             w_sample;

  // Debounce state
  logic [15:0]      r_prev;
  logic [STB_W-1:0] r_stable;
  logic             r_reported;
  logic [STB_W-1:0] w_stable_nxt;
  logic [4:0]       w_ones;
  logic [3:0]       w_code;
  logic             w_push;

  // FIFO state
  logic [3:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_level;
  logic [CNT_W-1:0] w_level_nxt;
  logic             r_empty;
  logic             r_overflow;
  logic [31:0]      r_rd_data;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic             w_drop;

  assign w_sample = (r_dwell == DWELL_LAST);
  assign cols     = ~(4'b0001 << r_col_idx);

  // Column walk: count the dwell, capture the rows on its last cycle, then move to the next column
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_idx   <= '0;
      r_dwell     <= '0;
      r_frame_acc <= '0;
      r_frame     <= '0;
      r_frame_vld <= 1'b0;
    end else begin
      r_frame_vld <= 1'b0;
      if (w_sample) begin
        r_dwell   <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        case (r_col_idx)
          2'd0:    r_frame_acc[3:0]  <= ~rows;
          2'd1:    r_frame_acc[7:4]  <= ~rows;
          2'd2:    r_frame_acc[11:8] <= ~rows;
          default: begin
            r_frame     <= {~rows, r_frame_acc};
            r_frame_vld <= 1'b1;
          end
        endcase
      end else begin
        r_dwell <= r_dwell + DIV_W'(1);
      end
    end
  end

  // Frame classification: number of pressed switches and the code of the (last) one found
  always_comb begin
    w_ones = '0;
    w_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (r_frame[i]) begin
        w_ones = w_ones + 5'd1;
        w_code = 4'(i);
      end
    end
  end

  // Debounce decision for a freshly completed frame
  always_comb begin
    w_stable_nxt = r_stable;
    w_push       = 1'b0;
    if (r_frame_vld) begin
      if (r_frame == r_prev) begin
        w_stable_nxt = (r_stable == STB_MAX) ? STB_MAX : r_stable + STB_W'(1);
      end else begin
        w_stable_nxt = STB_W'(1);
      end
      w_push = (w_stable_nxt == STB_MAX) && (w_ones == 5'd1) && !r_reported;
    end
  end

  // Debounce state: remember the last frame, its stability, and whether the held key was reported
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev     <= '0;
      r_stable   <= '0;
      r_reported <= 1'b0;
    end else if (r_frame_vld) begin
      r_prev   <= r_frame;
      r_stable <= w_stable_nxt;
      if (w_stable_nxt == STB_MAX) begin
        if (w_ones == 5'd0) begin
          r_reported <= 1'b0;
        end else if (w_ones == 5'd1) begin
          r_reported <= 1'b1;
        end
      end
    end
  end

  // A pop frees a slot for a same-cycle push, so a full FIFO only drops when not being read
  assign w_pop  = rd_en && (r_level != '0);
  assign w_full = (r_level == LVL_FULL);
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  // Occupancy after this edge's push/pop
  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr, w_pop})
      2'b10:   w_level_nxt = r_level + CNT_W'(1);
      2'b01:   w_level_nxt = r_level - CNT_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Event storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (w_wr && !reset) begin
      r_mem[r_wr_ptr] <= w_code;
    end
  end

  // FIFO pointers, flags, sticky overflow and the registered read word
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        r_rd_data <= w_pop ? {1'b1, 27'd0, r_mem[r_rd_ptr]} : 32'd0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
    end
  end

  assign rd_data  = r_rd_data;
  assign empty    = r_empty;
  assign overflow = r_overflow;
  assign level    = r_level;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// tb/tb_keypad_scan_controller.sv - randomized self-checking bench with a keypad and event-queue reference model
`timescale 1ns/1ps
module tb_keypad_scan_controller;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = 4;

  logic             clk     = 1'b0;
  logic             reset   = 1'b1;
  logic [3:0]       rows;
  logic [3:0]       cols;
  logic             rd_en   = 1'b0;
  logic             clr_ovf = 1'b0;
  logic [31:0]      rd_data;
  logic             empty;
  logic             overflow;
  logic [CNT_W-1:0] level;

  // Switch matrix: bit (col*4 + row) closed means that key is held
  logic [15:0] keys = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] m_prev;
  int          m_stable;
  bit          m_reported;
  int          m_q[$];
  bit          m_ovf;
  logic [31:0] m_rd;

  keypad_scan_controller #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols), .rd_en(rd_en), .clr_ovf(clr_ovf),
    .rd_data(rd_data), .empty(empty), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  // Physical keypad: a held key pulls its row low while its column is driven
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (cols[c] === 1'b0 && keys[c*4 + r]) rows[r] = 1'b0;
      end
    end
  end

  function automatic void model_reset();
    m_prev     = '0;
    m_stable   = 0;
    m_reported = 1'b0;
    m_q.delete();
    m_ovf      = 1'b0;
    m_rd       = '0;
  endfunction

  function automatic void model_frame(input logic [15:0] f);
    int n;
    int code;
    n    = $countones(f);
    code = 0;
    for (int b = 0; b < 16; b++) if (f[b]) code = b;
    if (f == m_prev) m_stable = (m_stable < DEB) ? m_stable + 1 : DEB;
    else             m_stable = 1;
    m_prev = f;
    if (m_stable == DEB) begin
      if (n == 1 && !m_reported) begin
        m_reported = 1'b1;
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else                     m_q.push_back(code);
      end else if (n == 0) begin
        m_reported = 1'b0;
      end
    end
  endfunction

  function automatic logic [31:0] model_pop();
    if (m_q.size() > 0) m_rd = 32'h8000_0000 | 32'(m_q.pop_front());
    else                m_rd = 32'd0;
    return m_rd;
  endfunction

  // Drive a pulse reset; returns one negedge after release, i.e. column 0 dwell cycle 1
  task automatic reset_dut(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  // One full 16-cycle scan frame with keys k; rd_mode 1 = read mid-frame, 2 = read on the push edge
  task automatic run_frame(input logic [15:0] k, input int rd_mode, input bit clr, input string tag);
    logic [31:0] exp_rd;
    keys = k;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 4) begin
        rd_en   = (rd_mode == 1);
        clr_ovf = clr;
      end
      if (i == 5) begin
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
        if (clr) m_ovf = 1'b0;
        if (rd_mode == 1) begin
          exp_rd = model_pop();
          n_checks++;
          if (rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL %s rd_data: got %h expected %h", tag, rd_data, exp_rd);
          end
        end
      end
      if (i == 15) rd_en = (rd_mode == 2);
      if (i == 16) rd_en = 1'b0;
    end
    if (rd_mode == 2) exp_rd = model_pop();
    model_frame(k);
    n_checks++;
    if (level !== CNT_W'(m_q.size())) begin
      n_fail++;
      $display("FAIL %s level: got %0d expected %0d", tag, level, m_q.size());
    end
    n_checks++;
    if (empty !== (m_q.size() == 0)) begin
      n_fail++;
      $display("FAIL %s empty: got %b expected %b", tag, empty, m_q.size() == 0);
    end
    n_checks++;
    if (overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL %s overflow: got %b expected %b", tag, overflow, m_ovf);
    end
    n_checks++;
    if (rd_data !== m_rd) begin
      n_fail++;
      $display("FAIL %s rd_data_hold: got %h expected %h", tag, rd_data, m_rd);
    end
  endtask

  task automatic press_release(input int code, input string tag);
    run_frame(16'(1) << code, 0, 1'b0, tag);
    run_frame(16'(1) << code, 0, 1'b0, tag);
    run_frame(16'h0000, 0, 1'b0, tag);
    run_frame(16'h0000, 0, 1'b0, tag);
  endtask

  task automatic test_reset();
    keys = '0;
    reset_dut(2);
    n_checks++;
    if (cols !== 4'b1110) begin n_fail++; $display("FAIL reset cols: got %b expected 1110", cols); end
    n_checks++;
    if (level !== '0) begin n_fail++; $display("FAIL reset level: got %0d expected 0", level); end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL reset empty: got %b expected 1", empty); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset overflow: got %b expected 0", overflow); end
    n_checks++;
    if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset rd_data: got %h expected 0", rd_data); end
  endtask

  task automatic test_idle();
    logic [3:0] exp_c;
    int pos;
    keys = '0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      pos   = (1 + i) % 16;
      exp_c = ~(4'b0001 << (pos / 4));
      n_checks++;
      if (cols !== exp_c) begin
        n_fail++;
        $display("FAIL idle cols step %0d: got %b expected %b", i, cols, exp_c);
      end
    end
    model_frame(16'h0000);
    model_frame(16'h0000);
    run_frame(16'h0000, 1, 1'b0, "idle_read");
  endtask

  task automatic test_single_press();
    for (int f = 0; f < 10; f++) run_frame(16'h0040, 0, 1'b0, "single_hold");
    n_checks++;
    if (level !== 4'd1) begin n_fail++; $display("FAIL single level: got %0d expected 1", level); end
    run_frame(16'h0000, 1, 1'b0, "single_read");
    n_checks++;
    if (rd_data !== 32'h8000_0006) begin n_fail++; $display("FAIL single rd_data: got %h expected 80000006", rd_data); end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL single empty: got %b expected 1", empty); end
    run_frame(16'h0000, 0, 1'b0, "single_release");
  endtask

  task automatic test_bounce();
    run_frame(16'h1000, 0, 1'b0, "bounce");
    run_frame(16'h0000, 0, 1'b0, "bounce");
    run_frame(16'h1000, 0, 1'b0, "bounce");
    run_frame(16'h0000, 0, 1'b0, "bounce");
    run_frame(16'h0000, 0, 1'b0, "bounce");
    n_checks++;
    if (level !== 4'd0) begin n_fail++; $display("FAIL bounce level: got %0d expected 0", level); end
  endtask

  task automatic test_multi();
    for (int f = 0; f < 5; f++) run_frame(16'h0021, 0, 1'b0, "multi");
    n_checks++;
    if (level !== 4'd0) begin n_fail++; $display("FAIL multi level: got %0d expected 0", level); end
    for (int f = 0; f < 3; f++) run_frame(16'h0001, 0, 1'b0, "multi_single");
    n_checks++;
    if (level !== 4'd1) begin n_fail++; $display("FAIL multi_single level: got %0d expected 1", level); end
    run_frame(16'h0000, 1, 1'b0, "multi_read");
    n_checks++;
    if (rd_data !== 32'h8000_0000) begin n_fail++; $display("FAIL multi rd_data: got %h expected 80000000", rd_data); end
    run_frame(16'h0000, 0, 1'b0, "multi_release");
  endtask

  task automatic test_overflow();
    for (int c = 1; c <= 5; c++) press_release(c, "ovf_fill");
    n_checks++;
    if (level !== 4'd4) begin n_fail++; $display("FAIL ovf level: got %0d expected 4", level); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf flag: got %b expected 1", overflow); end
    for (int c = 1; c <= 4; c++) begin
      run_frame(16'h0000, 1, 1'b0, "ovf_drain");
      n_checks++;
      if (rd_data !== (32'h8000_0000 | 32'(c))) begin
        n_fail++;
        $display("FAIL ovf drain %0d rd_data: got %h expected %h", c, rd_data, 32'h8000_0000 | 32'(c));
      end
    end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf empty: got %b expected 1", empty); end
    run_frame(16'h0000, 0, 1'b1, "ovf_clear");
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf clear: got %b expected 0", overflow); end
  endtask

  task automatic test_back_to_back();
    for (int c = 8; c <= 11; c++) press_release(c, "b2b_fill");
    run_frame(16'h0080, 0, 1'b0, "b2b_full");
    run_frame(16'h0080, 2, 1'b0, "b2b_full_pushpop");
    n_checks++;
    if (rd_data !== 32'h8000_0008) begin n_fail++; $display("FAIL b2b full rd_data: got %h expected 80000008", rd_data); end
    n_checks++;
    if (level !== 4'd4) begin n_fail++; $display("FAIL b2b full level: got %0d expected 4", level); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b full overflow: got %b expected 0", overflow); end
    for (int r = 0; r < 4; r++) run_frame(16'h0000, 1, 1'b0, "b2b_drain");
    run_frame(16'h4000, 0, 1'b0, "b2b_empty");
    run_frame(16'h4000, 2, 1'b0, "b2b_empty_pushpop");
    n_checks++;
    if (rd_data !== 32'd0) begin n_fail++; $display("FAIL b2b empty rd_data: got %h expected 0", rd_data); end
    n_checks++;
    if (level !== 4'd1) begin n_fail++; $display("FAIL b2b empty level: got %0d expected 1", level); end
    run_frame(16'h0000, 1, 1'b0, "b2b_read");
    run_frame(16'h0000, 0, 1'b0, "b2b_release");
  endtask

  task automatic test_reset_mid();
    press_release(2, "rmid_fill");
    press_release(3, "rmid_fill");
    press_release(13, "rmid_fill");
    run_frame(16'h0010, 1, 1'b0, "rmid_hold");
    keys = 16'h0010;
    repeat (7) @(negedge clk);
    reset_dut(1);
    n_checks++;
    if (level !== 4'd0) begin n_fail++; $display("FAIL rmid level: got %0d expected 0", level); end
    n_checks++;
    if (rd_data !== 32'd0) begin n_fail++; $display("FAIL rmid rd_data: got %h expected 0", rd_data); end
    n_checks++;
    if (cols !== 4'b1110) begin n_fail++; $display("FAIL rmid cols: got %b expected 1110", cols); end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL rmid empty: got %b expected 1", empty); end
    run_frame(16'h0010, 0, 1'b0, "rmid_redebounce1");
    n_checks++;
    if (level !== 4'd0) begin n_fail++; $display("FAIL rmid frame1 level: got %0d expected 0", level); end
    run_frame(16'h0010, 0, 1'b0, "rmid_redebounce2");
    n_checks++;
    if (level !== 4'd1) begin n_fail++; $display("FAIL rmid frame2 level: got %0d expected 1", level); end
    run_frame(16'h0010, 1, 1'b0, "rmid_read");
    n_checks++;
    if (rd_data !== 32'h8000_0004) begin n_fail++; $display("FAIL rmid rd_data: got %h expected 80000004", rd_data); end
    run_frame(16'h0000, 0, 1'b0, "rmid_release");
    run_frame(16'h0000, 0, 1'b0, "rmid_release");
  endtask

  task automatic test_random();
    logic [15:0] k;
    int sel, hold, a, b, rm;
    bit cl;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        k = '0;
      end else if (sel < 8) begin
        k = 16'(1) << $urandom_range(0, 15);
      end else begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        k = (16'(1) << a) | (16'(1) << b);
      end
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        sel = $urandom_range(0, 9);
        rm  = (sel < 6) ? 0 : ((sel < 8) ? 1 : 2);
        cl  = ($urandom_range(0, 7) == 0);
        run_frame(k, rm, cl, "random");
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_single_press();
    test_bounce();
    test_multi();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
